// File: rtl/trim_sort_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// trim_sort_pkg
// Shared constants, state encoding and small helpers for the alpha-trimmed
// mean filter controller (trim_sort_ctrl) and its interface.
//   DN       pixels per 5x5 window
//   DW       pixel width
//   DW_SEQ   width of one sorter output index
//   AW       width of the per-side trim count input
//   SUM_W    accumulator width (DN * max pixel fits without overflow)
//   CNT_W    width of the retained-pixel count
// -----------------------------------------------------------------------------
package trim_sort_pkg;

    localparam int DN        = 25;
    localparam int DW        = 8;
    localparam int DW_SEQ    = $clog2(DN);
    localparam int AW        = $clog2(DN / 2 + 1);
    localparam int SUM_W     = DW + $clog2(DN + 1);
    localparam int CNT_W     = DW_SEQ + 1;
    // Largest trim that still leaves one pixel (the median) in the window.
    localparam int ALPHA_MAX = (DN - 1) / 2;

    typedef enum logic [5:0] {
        S_IDLE    = 6'b000001,
        S_LAUNCH  = 6'b000010,
        S_WAIT    = 6'b000100,
        S_CAPTURE = 6'b001000,
        S_ACCUM   = 6'b010000,
        S_OUTPUT  = 6'b100000
    } state_t;

    // Pixel at original position idx. Written as an explicit mux so an
    // out-of-range index from a misbehaving sorter yields 0, never X.
    function automatic logic [DW-1:0] pix_sel(input logic [DN*DW-1:0]   buffer,
                                              input logic [DW_SEQ-1:0] idx);
        logic [DW-1:0] p;
        p = '0;
        for (int i = 0; i < DN; i++) begin
            if (idx == DW_SEQ'(i)) begin
                p = buffer[i*DW +: DW];
            end
        end
        return p;
    endfunction

    // Trim count per side, limited so at least one pixel is retained.
    function automatic logic [DW_SEQ-1:0] clamp_alpha(input logic [AW-1:0] alpha);
        logic [DW_SEQ-1:0] a;
        if (alpha > AW'(ALPHA_MAX)) begin
            a = DW_SEQ'(ALPHA_MAX);
        end else begin
            a = DW_SEQ'(alpha);
        end
        return a;
    endfunction

endpackage

// File: rtl/trim_sort_ctrl_if.sv
// -----------------------------------------------------------------------------
// trim_sort_ctrl_if
// Bundles the window input handshake, the sorter launch/return path and the
// result handshake towards the divider stage.
//   master : the controller (drives win_ready, sort_sig, data_unsort, out_*,
//            err_timeout)
//   slave  : the surroundings (window source, sorter, divider)
// -----------------------------------------------------------------------------
interface trim_sort_ctrl_if;
    import trim_sort_pkg::*;

    logic                     win_valid;
    logic                     win_ready;
    logic [DW*DN-1:0]         win_data;
    logic [AW-1:0]            alpha;
    logic                     sort_sig;
    logic [DW*DN-1:0]         data_unsort;
    logic                     sort_finish;
    logic [DW_SEQ*DN-1:0]     sequence_sorted;
    logic                     out_valid;
    logic                     out_ready;
    logic [SUM_W-1:0]         out_sum;
    logic [CNT_W-1:0]         out_cnt;
    logic                     err_timeout;

    modport master (
        input  win_valid, win_data, alpha, sort_finish, sequence_sorted, out_ready,
        output win_ready, sort_sig, data_unsort, out_valid, out_sum, out_cnt, err_timeout
    );

    modport slave (
        output win_valid, win_data, alpha, sort_finish, sequence_sorted, out_ready,
        input  win_ready, sort_sig, data_unsort, out_valid, out_sum, out_cnt, err_timeout
    );

endinterface

// File: rtl/trim_sort_ctrl.sv
// -----------------------------------------------------------------------------
// trim_sort_ctrl
// Sequences one shared parallel_sort engine for the modified alpha-trimmed
// mean filter: accepts a window, launches the sort, captures the sorted index
// list, serially sums the middle DN-2*alpha_eff pixels and hands sum and
// count to the divider.
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset (shared with the sorter)
//   bus      trim_sort_ctrl_if.master - window in, sorter link, result out
// Parameters:
//   TIMEOUT  cycles allowed from sort_sig to sort_finish
// -----------------------------------------------------------------------------
module trim_sort_ctrl
    import trim_sort_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    trim_sort_ctrl_if.master  bus
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t                 state_reg;
    logic [DW*DN-1:0]       win_buf_reg;
    logic [DW_SEQ*DN-1:0]   idx_buf_reg;
    logic [DW_SEQ-1:0]      alpha_eff_reg;
    logic [DW_SEQ-1:0]      k_reg;
    logic [DW_SEQ-1:0]      k_last_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [SUM_W-1:0]       acc_reg;
    logic [TMO_W-1:0]       tmo_reg;
    logic                   win_ready_reg;
    logic                   sort_sig_reg;
    logic                   out_valid_reg;
    logic [SUM_W-1:0]       out_sum_reg;
    logic [CNT_W-1:0]       out_cnt_reg;
    logic                   err_timeout_reg;

    logic [DW_SEQ-1:0]      alpha_in;
    logic [DW_SEQ-1:0]      idx_cur;
    logic [DW-1:0]          pix_cur;

    assign alpha_in = clamp_alpha(bus.alpha);
    // Original position of the k-th smallest pixel, then that pixel's value.
    assign idx_cur  = idx_buf_reg[int'(k_reg)*DW_SEQ +: DW_SEQ];
    assign pix_cur  = pix_sel(win_buf_reg, idx_cur);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            win_buf_reg     <= '0;
            idx_buf_reg     <= '0;
            alpha_eff_reg   <= '0;
            k_reg           <= '0;
            k_last_reg      <= '0;
            cnt_reg         <= '0;
            acc_reg         <= '0;
            tmo_reg         <= '0;
            win_ready_reg   <= 1'b0;
            sort_sig_reg    <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_sum_reg     <= '0;
            out_cnt_reg     <= '0;
            err_timeout_reg <= 1'b0;
        end else begin
            // Single-cycle pulses.
            sort_sig_reg    <= 1'b0;
            err_timeout_reg <= 1'b0;

            unique case (state_reg)
                S_IDLE: begin
                    if (bus.win_valid && win_ready_reg) begin
                        win_buf_reg   <= bus.win_data;
                        alpha_eff_reg <= alpha_in;
                        k_last_reg    <= DW_SEQ'(DN - 1) - alpha_in;
                        cnt_reg       <= CNT_W'(DN) - {alpha_in, 1'b0};
                        win_ready_reg <= 1'b0;
                        sort_sig_reg  <= 1'b1;
                        state_reg     <= S_LAUNCH;
                    end else begin
                        // Also raises ready on the first clock after reset.
                        win_ready_reg <= 1'b1;
                    end
                end

                S_LAUNCH: begin
                    // sort_sig is high during this cycle; counting starts here.
                    tmo_reg   <= TMO_W'(1);
                    state_reg <= S_WAIT;
                end

                S_WAIT: begin
                    if (bus.sort_finish) begin
                        state_reg <= S_CAPTURE;
                    end else if (tmo_reg == TMO_W'(TIMEOUT - 1)) begin
                        // Pulse lands exactly TIMEOUT cycles after sort_sig.
                        err_timeout_reg <= 1'b1;
                        win_ready_reg   <= 1'b1;
                        state_reg       <= S_IDLE;
                    end else begin
                        tmo_reg <= tmo_reg + TMO_W'(1);
                    end
                end

                S_CAPTURE: begin
                    // The index list is only valid the cycle after sort_finish.
                    idx_buf_reg <= bus.sequence_sorted;
                    acc_reg     <= '0;
                    k_reg       <= alpha_eff_reg;
                    state_reg   <= S_ACCUM;
                end

                S_ACCUM: begin
                    if (k_reg == k_last_reg) begin
                        out_sum_reg   <= acc_reg + SUM_W'(pix_cur);
                        out_cnt_reg   <= cnt_reg;
                        out_valid_reg <= 1'b1;
                        state_reg     <= S_OUTPUT;
                    end else begin
                        acc_reg <= acc_reg + SUM_W'(pix_cur);
                        k_reg   <= k_reg + DW_SEQ'(1);
                    end
                end

                S_OUTPUT: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        win_ready_reg <= 1'b1;
                        state_reg     <= S_IDLE;
                    end
                end

                default: begin
                    // Illegal one-hot code: drop whatever was in flight.
                    out_valid_reg <= 1'b0;
                    win_ready_reg <= 1'b0;
                    state_reg     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.win_ready   = win_ready_reg;
    assign bus.sort_sig    = sort_sig_reg;
    assign bus.data_unsort = win_buf_reg;
    assign bus.out_valid   = out_valid_reg;
    assign bus.out_sum     = out_sum_reg;
    assign bus.out_cnt     = out_cnt_reg;
    assign bus.err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_trim_sort_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trim_sort_ctrl
// Drives windows into trim_sort_ctrl, stands in for the parallel_sort engine
// (fixed 3-cycle finish, index list valid the cycle after), and compares each
// result against a sort-the-values reference of the trimmed mean sum.
// -----------------------------------------------------------------------------
module tb_trim_sort_ctrl;
    import trim_sort_pkg::*;

    typedef logic [DW-1:0] win_t [DN];

    logic clk;
    logic rst_n;

    trim_sort_ctrl_if bus();

    trim_sort_ctrl #(.TIMEOUT(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;
    bit sorter_en = 1'b1;
    bit stub_pend = 1'b0;
    int stub_fin = 0;
    logic [DW_SEQ*DN-1:0] stub_perm;
    logic [DW_SEQ*DN-1:0] stub_junk;
    int sig_count = 0;
    int sig_cyc = 0;
    int ov_count = 0;
    int err_count = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: sort the pixel values, drop alpha_eff from each end, sum the rest.
    function automatic int ref_alpha(input int alpha);
        return (alpha > (DN - 1) / 2) ? (DN - 1) / 2 : alpha;
    endfunction

    function automatic int ref_sum(input win_t pix, input int alpha);
        int q[$];
        int a;
        int s;
        a = ref_alpha(alpha);
        for (int i = 0; i < DN; i++) q.push_back(int'(pix[i]));
        q.sort();
        s = 0;
        for (int k = a; k < DN - a; k++) s += q[k];
        return s;
    endfunction

    // Sorter stand-in: argsort of data_unsort, finish pulse 3 cycles after
    // sort_sig, junk indices during the finish cycle, real list afterwards.
    initial begin
        bus.sort_finish     = 1'b0;
        bus.sequence_sorted = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                stub_pend       = 1'b0;
                bus.sort_finish = 1'b0;
            end else begin
                if (stub_pend && cyc == stub_fin) begin
                    for (int k = 0; k < DN; k++) stub_junk[k*DW_SEQ +: DW_SEQ] = DW_SEQ'($urandom_range(0, DN - 1));
                    bus.sort_finish     = 1'b1;
                    bus.sequence_sorted = stub_junk;
                end else if (stub_pend && cyc == stub_fin + 1) begin
                    bus.sort_finish     = 1'b0;
                    bus.sequence_sorted = stub_perm;
                    stub_pend           = 1'b0;
                end
                if (bus.sort_sig && sorter_en) begin
                    int ord[DN];
                    int tmp;
                    for (int i = 0; i < DN; i++) ord[i] = i;
                    for (int i = 0; i < DN - 1; i++) begin
                        for (int j = 0; j < DN - 1 - i; j++) begin
                            if (bus.data_unsort[ord[j]*DW +: DW] > bus.data_unsort[ord[j+1]*DW +: DW]) begin
                                tmp = ord[j]; ord[j] = ord[j+1]; ord[j+1] = tmp;
                            end
                        end
                    end
                    for (int k = 0; k < DN; k++) stub_perm[k*DW_SEQ +: DW_SEQ] = DW_SEQ'(ord[k]);
                    stub_pend = 1'b1;
                    stub_fin  = cyc + 3;
                end
            end
        end
    end

    // Event monitor.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.sort_sig) begin sig_count++; sig_cyc = cyc; end
            if (bus.out_valid) ov_count++;
            if (bus.err_timeout) err_count++;
        end
    end

    task automatic accept_window(input win_t pix, input int alpha, output int a_cyc);
        int budget;
        for (int i = 0; i < DN; i++) bus.win_data[i*DW +: DW] = pix[i];
        bus.alpha     = AW'(alpha);
        bus.win_valid = 1'b1;
        budget = 0;
        while (!bus.win_ready && budget < 200) begin step(); budget++; end
        check_eq("accept_wait", bus.win_ready, 1'b1);
        a_cyc = cyc;
    endtask

    task automatic run_window(input win_t pix, input int alpha, input int stall, input bit hold_valid);
        int a_cyc;
        int budget;
        int exp_sum;
        int exp_cnt;
        sig_count     = 0;
        bus.out_ready = 1'b0;
        accept_window(pix, alpha, a_cyc);
        step();
        if (!hold_valid) bus.win_valid = 1'b0;
        budget = 0;
        while (!bus.out_valid && budget < 100) begin step(); budget++; end
        check_eq("out_wait", bus.out_valid, 1'b1);
        exp_sum = ref_sum(pix, alpha);
        exp_cnt = DN - 2 * ref_alpha(alpha);
        check_eq("latency", cyc - a_cyc, 6 + exp_cnt);
        check_eq("sort_sig_cycle", sig_cyc, a_cyc + 1);
        check_eq("out_sum", bus.out_sum, exp_sum);
        check_eq("out_cnt", bus.out_cnt, exp_cnt);
        for (int i = 0; i < stall; i++) begin
            step();
            check_eq("stall_valid", bus.out_valid, 1'b1);
            check_eq("stall_sum", bus.out_sum, exp_sum);
            check_eq("stall_cnt", bus.out_cnt, exp_cnt);
            check_eq("stall_win_ready", bus.win_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_eq("valid_drop", bus.out_valid, 1'b0);
        check_eq("ready_back", bus.win_ready, 1'b1);
        check_eq("sort_sig_once", sig_count, 1);
        $display("window alpha=%0d stall=%0d sum=%0d cnt=%0d accept=%0d", alpha, stall, exp_sum, exp_cnt, a_cyc);
    endtask

    initial begin
        win_t w;
        int a_cyc;
        int budget;

        rst_n         = 1'b0;
        bus.win_valid = 1'b0;
        bus.win_data  = '0;
        bus.alpha     = '0;
        bus.out_ready = 1'b0;

        step();
        step();
        check_eq("rst_win_ready", bus.win_ready, 1'b0);
        check_eq("rst_sort_sig", bus.sort_sig, 1'b0);
        check_eq("rst_data_unsort_nz", |bus.data_unsort, 1'b0);
        check_eq("rst_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_out_sum", bus.out_sum, 0);
        check_eq("rst_out_cnt", bus.out_cnt, 0);
        check_eq("rst_err_timeout", bus.err_timeout, 1'b0);
        rst_n = 1'b1;
        step();
        check_eq("idle_win_ready", bus.win_ready, 1'b1);

        // Descending pixels, alpha 5.
        for (int i = 0; i < DN; i++) w[i] = DW'(24 - i);
        run_window(w, 5, 0, 1'b0);

        // All equal, alpha 2.
        for (int i = 0; i < DN; i++) w[i] = DW'(7);
        run_window(w, 2, 0, 1'b0);

        // Permutation, alpha clamped from 15 to 12: median only.
        for (int i = 0; i < DN; i++) w[i] = DW'((i * 7) % 25);
        run_window(w, 15, 0, 1'b0);

        // Back-pressure with win_valid held high, then the next window.
        for (int i = 0; i < DN; i++) w[i] = DW'($urandom_range(0, 255));
        run_window(w, 3, 10, 1'b1);
        for (int i = 0; i < DN; i++) w[i] = DW'($urandom_range(0, 255));
        run_window(w, 1, 0, 1'b0);

        // Sorter never answers.
        sorter_en = 1'b0;
        ov_count  = 0;
        for (int i = 0; i < DN; i++) w[i] = DW'($urandom_range(0, 255));
        accept_window(w, 4, a_cyc);
        step();
        bus.win_valid = 1'b0;
        budget = 0;
        while (!bus.err_timeout && budget < 100) begin step(); budget++; end
        check_eq("tmo_seen", bus.err_timeout, 1'b1);
        check_eq("tmo_delay", cyc - (a_cyc + 1), 64);
        check_eq("tmo_win_ready", bus.win_ready, 1'b1);
        step();
        check_eq("tmo_pulse_width", bus.err_timeout, 1'b0);
        step();
        check_eq("tmo_no_output", ov_count, 0);
        $display("timeout window accept=%0d err_at=%0d", a_cyc, cyc - 2);
        sorter_en = 1'b1;

        // Reset during accumulation.
        ov_count = 0;
        for (int i = 0; i < DN; i++) w[i] = DW'($urandom_range(0, 255));
        accept_window(w, 0, a_cyc);
        step();
        bus.win_valid = 1'b0;
        while (cyc < a_cyc + 10) step();
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", bus.out_valid, 1'b0);
        check_eq("midrst_win_ready", bus.win_ready, 1'b0);
        check_eq("midrst_out_sum", bus.out_sum, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check_eq("midrst_no_output", ov_count, 0);
        $display("reset during accumulate at cycle %0d", a_cyc + 10);
        for (int i = 0; i < DN; i++) w[i] = DW'(i);
        run_window(w, 0, 0, 1'b0);

        // Random windows, trims and stalls.
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < DN; i++) w[i] = DW'($urandom_range(0, 255));
            run_window(w, $urandom_range(0, 15), $urandom_range(0, 3), 1'b0);
        end

        check_eq("tmo_total", err_count, 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/trim_sort_ctrl.md
Name: trim_sort_ctrl

Overview:
- Sequences one shared parallel_sort engine for the modified alpha-trimmed mean filter.
- Accepts a 5x5 window over a valid/ready handshake and holds it in a local buffer.
- Launches the sort, captures the sorted index list, then serially accumulates the middle DN-2*alpha pixels.
- Emits sum and count to the downstream divider stage.

Parameters:
DN, 25, pixels per window
DW, 8, pixel width
DW_SEQ, $clog2(DN), index width of sorter output
AW, $clog2(DN/2+1), width of alpha trim input
SUM_W, DW+$clog2(DN+1), accumulator width
TIMEOUT, 64, max cycles from sort_sig to sort_finish before error

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
win_valid  in  1  window available
win_ready  out  1  controller can accept window
win_data  in  DW*DN  window pixels, pixel i at [i*DW+:DW]
alpha  in  AW  trim count per side, sampled on window accept
sort_sig  out  1  one-cycle launch pulse to sorter
data_unsort  out  DW*DN  buffered window driven to sorter
sort_finish  in  1  sorter done pulse
sequence_sorted  in  DW_SEQ*DN  slot k holds original index of k-th smallest pixel
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_sum  out  SUM_W  sum of retained pixels
out_cnt  out  DW_SEQ+1  number of retained pixels (DN-2*alpha_eff)
err_timeout  out  1  one-cycle pulse on sorter timeout

Behaviour:
- Reset: state IDLE; win_ready=0 during reset, 1 in IDLE. sort_sig=0, data_unsort=0, out_valid=0, out_sum=0, out_cnt=0, err_timeout=0.
- States: IDLE, LAUNCH, WAIT, CAPTURE, ACCUM, OUTPUT.
- IDLE: win_ready=1. On win_valid, latch win_data into the buffer and latch alpha_eff = min(alpha, (DN-1)/2), so at least 1 pixel is always retained. Go to LAUNCH.
- LAUNCH: sort_sig=1 for exactly one cycle (cycle T); data_unsort = buffer, held stable until return to IDLE. Go to WAIT.
- WAIT: sort_finish arrives at T+3. Go to CAPTURE.
  - Timeout counter starts at T. If it reaches TIMEOUT without sort_finish, pulse err_timeout, go to IDLE, produce no output.
  - sort_finish seen in any other state is ignored.
- CAPTURE (T+4): sequence_sorted is valid only from the cycle after sort_finish. Register it into an index buffer; clear acc; set k=alpha_eff. Go to ACCUM.
- ACCUM: each cycle acc += buffer[idx[k]], k++. Runs while k <= DN-1-alpha_eff, i.e. count = DN-2*alpha_eff cycles. After the last add, go to OUTPUT.
- OUTPUT: out_valid=1 with out_sum=acc, out_cnt=count, both held stable while out_ready=0. On out_valid&&out_ready, go to IDLE with win_ready=1 the next cycle.
- Latency, accept cycle A to out_valid: A+6+count.
  - alpha=0: A+31.
  - alpha=12: A+7.
- One window in flight at a time; win_ready=0 outside IDLE.
- Ties: the sorter gives duplicate pixels distinct ranks, so index list is a permutation; no special handling.
- Arithmetic: acc is unsigned SUM_W bits; cannot overflow (max 25*255=6375).
- Reset mid-operation: all state discarded, no partial output. Sorter shares rst_n.

Decomposition:
- Package trim_sort_pkg: DN, DW, DW_SEQ, SUM_W, state enum (one-hot, 6 bits), and function pix_sel(buffer, idx) returning the DW-bit pixel at index idx.
- No sub-module: parallel_sort is instantiated beside this block at the filter top level, not inside it.

Test Plan:
- Window pixel i = 24-i, alpha=5, out_ready=1 -> out_sum=180, out_cnt=15, out_valid at A+21, sort_sig exactly once.
- All pixels 7, alpha=2 -> out_sum=147, out_cnt=21; duplicate ranks handled.
- Pixel i = (i*7)%25, alpha=15 (clamped to 12) -> out_cnt=1, out_sum=12 (median), out_valid at A+7.
- out_ready low 10 cycles in OUTPUT, win_valid held high -> out_sum/out_cnt stable, win_ready=0 throughout, next window accepted only after handshake.
- Stub sorter never asserts sort_finish -> err_timeout pulse exactly 64 cycles after sort_sig, back to IDLE, out_valid never 1.
- Assert rst_n low during ACCUM -> out_valid=0, state IDLE after release; next window (alpha=0, pixels 0..24) -> out_sum=300, out_cnt=25.
